// File: rtl/freecell_move_sequencer.sv
// ---------------------------------------------------------------------------
// freecell_move_sequencer
//
// Move-issue controller that sits in front of the freecellPlayer datapath.
// Encoded moves from the host are buffered in a small circular FIFO. Once
// started, the sequencer issues at most one (source, dest) pair per clock to
// the player. Moves that can never be legal are dropped at enqueue. Issued
// and rejected moves are counted with saturating counters. When the player
// reports a win, the game freezes.
//
// Move codes: 0-7 tableau column, 8-11 free cell a-d, 12-15 home.
//
// Ports
//   clock          in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   in_valid       in   host offers a move
//   in_ready       out  move accepted this cycle (not WON and FIFO not full)
//   in_source      in   [3:0] offered move source
//   in_dest        in   [3:0] offered move destination
//   start          in   single-cycle pulse, IDLE -> RUN
//   win            in   game won indication from the player (honoured in RUN)
//   source         out  [3:0] issued move source
//   dest           out  [3:0] issued move destination
//   move_valid     out  source/dest carry a newly issued move this cycle
//   issued_count   out  [CNT_W-1:0] issued moves, saturating
//   rejected_count out  [CNT_W-1:0] moves dropped at enqueue, saturating
//   busy           out  state is RUN
//   done           out  state is WON
// ---------------------------------------------------------------------------
module freecell_move_sequencer #(
    parameter int DEPTH = 8,   // power of two, at least 2
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_source,
    input  logic [3:0]       in_dest,
    input  logic             start,
    input  logic             win,
    output logic [3:0]       source,
    output logic [3:0]       dest,
    output logic             move_valid,
    output logic [CNT_W-1:0] issued_count,
    output logic [CNT_W-1:0] rejected_count,
    output logic             busy,
    output logic             done
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE_F = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WON  = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] dst;
    } move_t;

    // Registered state and its next-state values.
    state_e           state_q,    state_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W:0]   count_q,    count_d;
    logic [3:0]       source_q,   source_d;
    logic [3:0]       dest_q,     dest_d;
    logic             valid_q,    valid_d;
    logic [CNT_W-1:0] issued_q,   issued_d;
    logic [CNT_W-1:0] rejected_q, rejected_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    move_t mem_q [DEPTH];

    logic handshake;
    logic reject;
    logic push;
    logic pop;
    logic flush;

    // Readiness depends on registered state only, never on this cycle's inputs.
    assign in_ready  = (state_q != ST_WON) && (count_q != FIFO_FULL);
    assign handshake = in_valid && in_ready;
    // A move from home, or onto its own source, can never be legal.
    assign reject    = handshake && ((in_source[3:2] == 2'b11) || (in_source == in_dest));

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        source_d   = source_q;
        dest_d     = dest_q;
        valid_d    = 1'b0;
        issued_d   = issued_q;
        rejected_d = rejected_q;
        pop        = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (win) begin
                    state_d = ST_WON;
                    flush   = 1'b1;
                end else begin
                    pop = (count_q != '0);
                end
            end
            ST_WON: begin
                state_d = ST_WON;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A legal move arriving on the winning edge is discarded.
        push = handshake && !reject && !flush;

        if (reject && (rejected_q != '1)) begin
            rejected_d = rejected_q + CNT_ONE;
        end

        if (pop) begin
            source_d = mem_q[rd_ptr_q].src;
            dest_d   = mem_q[rd_ptr_q].dst;
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (issued_q != '1) begin
                issued_d = issued_q + CNT_ONE;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_ONE_F;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE_F;
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_WON);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            source_q   <= '0;
            dest_q     <= '0;
            valid_q    <= 1'b0;
            issued_q   <= '0;
            rejected_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            source_q   <= source_d;
            dest_q     <= dest_d;
            valid_q    <= valid_d;
            issued_q   <= issued_d;
            rejected_q <= rejected_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it
    // has been written, and count_q alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{src: in_source, dst: in_dest};
        end
    end

    assign source         = source_q;
    assign dest           = dest_q;
    assign move_valid     = valid_q;
    assign issued_count   = issued_q;
    assign rejected_count = rejected_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_freecell_move_sequencer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for freecell_move_sequencer.
// Two instances share one stimulus: dut (CNT_W = 8) and dut_sat (CNT_W = 2,
// exercising counter saturation). A reference model tracks the game as a
// queue of moves plus a phase variable and unbounded counts; every clock the
// outputs of both instances are compared with it, and each scenario adds
// its own directed expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_freecell_move_sequencer;

    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_source = '0;
    logic [3:0] in_dest = '0;
    logic       start = 1'b0;
    logic       win = 1'b0;

    logic       in_ready, move_valid, busy, done;
    logic [3:0] source, dest;
    logic [7:0] issued_count, rejected_count;

    logic       s_in_ready, s_move_valid, s_busy, s_done;
    logic [3:0] s_source, s_dest;
    logic [1:0] s_issued_count, s_rejected_count;

    freecell_move_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_source(in_source), .in_dest(in_dest), .start(start), .win(win),
        .source(source), .dest(dest), .move_valid(move_valid),
        .issued_count(issued_count), .rejected_count(rejected_count),
        .busy(busy), .done(done)
    );

    freecell_move_sequencer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_source(in_source), .in_dest(in_dest), .start(start), .win(win),
        .source(s_source), .dest(s_dest), .move_valid(s_move_valid),
        .issued_count(s_issued_count), .rejected_count(s_rejected_count),
        .busy(s_busy), .done(s_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_WON  = 2;

    typedef struct {
        logic [3:0] s;
        logic [3:0] d;
    } mv_t;

    mv_t        mq[$];
    int         m_phase;
    logic [3:0] m_src, m_dst;
    bit         m_valid;
    int         m_issued, m_rejected;

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase    = PH_IDLE;
        m_src      = '0;
        m_dst      = '0;
        m_valid    = 1'b0;
        m_issued   = 0;
        m_rejected = 0;
    endtask

    // One clock edge of the game, evaluated from the inputs held across it.
    task automatic model_edge();
        bit ready, hs, rej;
        mv_t m;
        ready = (m_phase != PH_WON) && (mq.size() < DEPTH);
        hs    = in_valid && ready;
        rej   = hs && ((in_source >= 4'd12) || (in_source == in_dest));
        if (rej) m_rejected++;
        m_valid = 1'b0;
        if (m_phase == PH_RUN && win) begin
            m_phase = PH_WON;
            mq.delete();
        end else begin
            if (m_phase == PH_RUN && mq.size() > 0) begin
                m = mq.pop_front();
                m_src   = m.s;
                m_dst   = m.d;
                m_valid = 1'b1;
                m_issued++;
            end
            if (hs && !rej) begin
                m.s = in_source;
                m.d = in_dest;
                mq.push_back(m);
            end
            if (m_phase == PH_IDLE && start) m_phase = PH_RUN;
        end
    endtask

    // Advance one clock, update the model and compare every output of both
    // instances with it, sampled 1 ns after the edge.
    task automatic tick();
        bit e_ready;
        @(posedge clock);
        model_edge();
        #1;
        e_ready = (m_phase != PH_WON) && (mq.size() < DEPTH);
        checks++;
        if (move_valid !== m_valid || (m_valid && (source !== m_src || dest !== m_dst))
            || (!m_valid && (source !== m_src || dest !== m_dst))) begin
            failures++;
            $display("FAIL sb_issue t=%0t got v=%b %0d/%0d want v=%b %0d/%0d",
                     $time, move_valid, source, dest, m_valid, m_src, m_dst);
        end
        checks++;
        if (issued_count !== 8'(sat(m_issued, 255)) || rejected_count !== 8'(sat(m_rejected, 255))) begin
            failures++;
            $display("FAIL sb_counts t=%0t got iss=%0d rej=%0d want iss=%0d rej=%0d",
                     $time, issued_count, rejected_count, sat(m_issued, 255), sat(m_rejected, 255));
        end
        checks++;
        if (s_issued_count !== 2'(sat(m_issued, 3)) || s_rejected_count !== 2'(sat(m_rejected, 3))) begin
            failures++;
            $display("FAIL sb_sat_counts t=%0t got iss=%0d rej=%0d want iss=%0d rej=%0d",
                     $time, s_issued_count, s_rejected_count, sat(m_issued, 3), sat(m_rejected, 3));
        end
        checks++;
        if (busy !== (m_phase == PH_RUN) || done !== (m_phase == PH_WON) || in_ready !== e_ready) begin
            failures++;
            $display("FAIL sb_status t=%0t got busy=%b done=%b rdy=%b want busy=%b done=%b rdy=%b",
                     $time, busy, done, in_ready, m_phase == PH_RUN, m_phase == PH_WON, e_ready);
        end
        checks++;
        if (s_move_valid !== m_valid || s_in_ready !== e_ready || s_busy !== busy || s_done !== done
            || s_source !== m_src || s_dest !== m_dst) begin
            failures++;
            $display("FAIL sb_sat_outputs t=%0t got v=%b rdy=%b %0d/%0d want v=%b rdy=%b %0d/%0d",
                     $time, s_move_valid, s_in_ready, s_source, s_dest, m_valid, e_ready, m_src, m_dst);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        start     = 1'b0;
        win       = 1'b0;
        in_source = '0;
        in_dest   = '0;
        reset_n   = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic push_move(input logic [3:0] s, input logic [3:0] d);
        in_valid  = 1'b1;
        in_source = s;
        in_dest   = d;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic push_random_legal();
        logic [3:0] s, d;
        s = 4'($urandom_range(0, 11));
        d = 4'((int'(s) + 1 + $urandom_range(0, 14)) % 16);
        push_move(s, d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (source !== 4'd0 || dest !== 4'd0 || move_valid !== 1'b0 || issued_count !== 8'd0
            || rejected_count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got src=%0d dst=%0d v=%b iss=%0d rej=%0d busy=%b done=%b rdy=%b want 0 0 0 0 0 0 0 1",
                     source, dest, move_valid, issued_count, rejected_count, busy, done, in_ready);
        end
        do_reset();
        tick();
    endtask

    task automatic test_ordering();
        do_reset();
        push_move(4'd0, 4'd12);
        push_move(4'd3, 4'd6);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || move_valid !== 1'b0) begin
            failures++;
            $display("FAIL order_start got busy=%b v=%b want busy=1 v=0", busy, move_valid);
        end
        tick();
        checks++;
        if (move_valid !== 1'b1 || source !== 4'd0 || dest !== 4'd12) begin
            failures++;
            $display("FAIL order_first got v=%b %0d/%0d want v=1 0/12", move_valid, source, dest);
        end
        tick();
        checks++;
        if (move_valid !== 1'b1 || source !== 4'd3 || dest !== 4'd6 || issued_count !== 8'd2) begin
            failures++;
            $display("FAIL order_second got v=%b %0d/%0d iss=%0d want v=1 3/6 iss=2",
                     move_valid, source, dest, issued_count);
        end
        tick();
        checks++;
        if (move_valid !== 1'b0 || source !== 4'd3 || dest !== 4'd6) begin
            failures++;
            $display("FAIL order_hold got v=%b %0d/%0d want v=0 3/6", move_valid, source, dest);
        end
    endtask

    task automatic test_rejection();
        do_reset();
        push_move(4'd12, 4'd3);
        push_move(4'd5, 4'd5);
        pulse_start();
        repeat (3) tick();
        checks++;
        if (rejected_count !== 8'd2 || issued_count !== 8'd0 || move_valid !== 1'b0) begin
            failures++;
            $display("FAIL reject_counts got rej=%0d iss=%0d v=%b want rej=2 iss=0 v=0",
                     rejected_count, issued_count, move_valid);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_random_legal();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got rdy=%b want 0", in_ready);
        end
        in_valid  = 1'b1;
        in_source = 4'd9;
        in_dest   = 4'd2;
        pulse_start();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL full_after_start got rdy=%b busy=%b want rdy=0 busy=1", in_ready, busy);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || move_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_first_pop got rdy=%b v=%b want rdy=1 v=1", in_ready, move_valid);
        end
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (issued_count !== 8'd9 || source !== 4'd9 || dest !== 4'd2) begin
            failures++;
            $display("FAIL wrap_total got iss=%0d last=%0d/%0d want iss=9 last=9/2",
                     issued_count, source, dest);
        end
    endtask

    task automatic test_win();
        do_reset();
        for (int i = 0; i < 4; i++) push_random_legal();
        pulse_start();
        tick();
        win = 1'b1;
        tick();
        win = 1'b0;
        checks++;
        if (move_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0
            || issued_count !== 8'd1) begin
            failures++;
            $display("FAIL win_edge got v=%b done=%b busy=%b rdy=%b iss=%0d want 0 1 0 0 1",
                     move_valid, done, busy, in_ready, issued_count);
        end
        in_valid  = 1'b1;
        in_source = 4'd1;
        in_dest   = 4'd2;
        start     = 1'b1;
        repeat (5) tick();
        in_valid  = 1'b0;
        start     = 1'b0;
        checks++;
        if (issued_count !== 8'd1 || move_valid !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL win_frozen got iss=%0d v=%b done=%b want iss=1 v=0 done=1",
                     issued_count, move_valid, done);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        for (int i = 0; i < 6; i++) push_random_legal();
        pulse_start();
        tick();
        tick();
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (source !== 4'd0 || dest !== 4'd0 || move_valid !== 1'b0 || issued_count !== 8'd0
            || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_async got src=%0d dst=%0d v=%b iss=%0d busy=%b done=%b rdy=%b",
                     source, dest, move_valid, issued_count, busy, done, in_ready);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        pulse_start();
        repeat (3) tick();
        checks++;
        if (move_valid !== 1'b0 || issued_count !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_empty got v=%b iss=%0d busy=%b want v=0 iss=0 busy=1",
                     move_valid, issued_count, busy);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) push_random_legal();
        pulse_start();
        repeat (8) tick();
        checks++;
        if (s_issued_count !== 2'd3 || issued_count !== 8'd5) begin
            failures++;
            $display("FAIL sat_issued got narrow=%0d wide=%0d want narrow=3 wide=5",
                     s_issued_count, issued_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_source = 4'($urandom_range(0, 15));
            in_dest   = ($urandom_range(0, 5) == 0) ? in_source : 4'($urandom_range(0, 15));
            start     = (i == 30);
            win       = (i == 350);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        win      = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL random_end got done=%b want 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_rejection();
        test_full_wrap();
        test_win();
        test_reset_mid_run();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
